rs_age_param: RTL

- Parametrised reservation station, successor to the single-ALU 16-entry RS.
- Sits between the issue stage and one execution unit. Holds up to DEPTH renamed instructions and snoops CDB_N result buses (ALU, LSB, …) for operand wakeup.
- Dispatches the oldest ready entry through a valid/ready output register.
- Adds over the previous generation: age-ordered selection, issue-cycle CDB capture, downstream backpressure, and a registered full/count.

---
 rtl/rs_age_param_pkg.sv | 29 ++
 rtl/rs_age_select.sv | 34 +++
 rtl/rs_age_param.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rs_age_param_pkg.sv
// ============================================================================
// Module      : rs_age_param_pkg
// Description : Shared defaults, opcode constants and CDB channel map for the
//               age-ordered reservation station.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rs_age_param_pkg;

  localparam int c_OP_W_DEF  = 7;
  localparam int c_ROB_W_DEF = 4;

  localparam logic [6:0] c_OP_LUI    = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_IMM    = 7'b0010011;
  localparam logic [6:0] c_OP_REG    = 7'b0110011;

  typedef enum int unsigned {
    CDB_ALU = 0,
    CDB_LSB = 1
  } cdb_chan_e;

endpackage

`default_nettype wire

// File: rtl/rs_age_select.sv
// ============================================================================
// Module      : rs_age_select
// Description : Oldest-ready picker; older[j*DEPTH+i] set means entry j is
//               older than entry i.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rs_age_select #(
  parameter int DEPTH = 8
) (
  input  logic [DEPTH-1:0]       ready,
  input  logic [DEPTH*DEPTH-1:0] older,
  output logic [DEPTH-1:0]       grant,
  output logic                   valid
);

  for (genvar i = 0; i < DEPTH; i++) begin : g_grant
    logic [DEPTH-1:0] w_blk;
    for (genvar j = 0; j < DEPTH; j++) begin : g_blk
      if (j == i) begin : g_self
        assign w_blk[j] = 1'b0;
      end else begin : g_other
        assign w_blk[j] = ready[j] && older[j*DEPTH+i];
      end
    end
    assign grant[i] = ready[i] && !(|w_blk);
  end

  assign valid = |ready;

endmodule

`default_nettype wire

// File: rtl/rs_age_param.sv
// ============================================================================
// Module      : rs_age_param
// Description : Parametrised reservation station with CDB wakeup and
//               age-ordered dispatch through a valid/ready output register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rs_age_param
  import rs_age_param_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ROB_W  = c_ROB_W_DEF,
  parameter int CDB_N  = 2,
  parameter int DATA_W = 32,
  parameter int OP_W   = c_OP_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      flush,
  input  logic                      issue_valid,
  input  logic [OP_W-1:0]           issue_op,
  input  logic [2:0]                issue_funct3,
  input  logic                      issue_funct7,
  input  logic [DATA_W-1:0]         issue_pc,
  input  logic [DATA_W-1:0]         issue_imm,
  input  logic [ROB_W-1:0]          issue_rob_pos,
  input  logic                      issue_rs1_pend,
  input  logic                      issue_rs2_pend,
  input  logic [ROB_W-1:0]          issue_rs1_tag,
  input  logic [ROB_W-1:0]          issue_rs2_tag,
  input  logic [DATA_W-1:0]         issue_rs1_val,
  input  logic [DATA_W-1:0]         issue_rs2_val,
  input  logic [CDB_N-1:0]          cdb_valid,
  input  logic [CDB_N*ROB_W-1:0]    cdb_tag,
  input  logic [CDB_N*DATA_W-1:0]   cdb_val,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OP_W-1:0]           out_op,
  output logic [2:0]                out_funct3,
  output logic                      out_funct7,
  output logic [DATA_W-1:0]         out_pc,
  output logic [DATA_W-1:0]         out_imm,
  output logic [ROB_W-1:0]          out_rob_pos,
  output logic [DATA_W-1:0]         out_val1,
  output logic [DATA_W-1:0]         out_val2,
  output logic                      full,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int c_IDX_W = $clog2(DEPTH);
  localparam int c_CNT_W = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0]            r_busy, r_p1, r_p2;
  logic [DEPTH-1:0][DEPTH-1:0] r_older;
  logic [ROB_W-1:0]            r_t1  [DEPTH];
  logic [ROB_W-1:0]            r_t2  [DEPTH];
  logic [DATA_W-1:0]           r_v1  [DEPTH];
  logic [DATA_W-1:0]           r_v2  [DEPTH];
  logic [OP_W-1:0]             r_op  [DEPTH];
  logic [2:0]                  r_f3  [DEPTH];
  logic                        r_f7  [DEPTH];
  logic [DATA_W-1:0]           r_pc  [DEPTH];
  logic [DATA_W-1:0]           r_imm [DEPTH];
  logic [ROB_W-1:0]            r_rob [DEPTH];

  logic                r_out_valid;
  logic [OP_W-1:0]     r_out_op;
  logic [2:0]          r_out_f3;
  logic                r_out_f7;
  logic [DATA_W-1:0]   r_out_pc, r_out_imm, r_out_v1, r_out_v2;
  logic [ROB_W-1:0]    r_out_rob;
  logic [c_CNT_W-1:0]  r_count;
  logic                r_full;

  // Lowest CDB channel wins when several carry the same tag.
  function automatic logic [DATA_W:0] f_lookup(
    input logic [ROB_W-1:0]        tag,
    input logic [CDB_N-1:0]        vld,
    input logic [CDB_N*ROB_W-1:0]  tags,
    input logic [CDB_N*DATA_W-1:0] vals
  );
    f_lookup = '0;
    for (int k = CDB_N - 1; k >= 0; k--) begin
      if (vld[k] && tags[k*ROB_W +: ROB_W] == tag)
        f_lookup = {1'b1, vals[k*DATA_W +: DATA_W]};
    end
  endfunction

  logic [DATA_W:0] w_look1 [DEPTH];
  logic [DATA_W:0] w_look2 [DEPTH];
  logic [DEPTH-1:0] w_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    assign w_look1[i] = f_lookup(r_t1[i], cdb_valid, cdb_tag, cdb_val);
    assign w_look2[i] = f_lookup(r_t2[i], cdb_valid, cdb_tag, cdb_val);
    assign w_ready[i] = r_busy[i] && !r_p1[i] && !r_p2[i];
  end

  logic [DATA_W:0]   w_ilook1, w_ilook2;
  logic [DATA_W-1:0] w_iv1, w_iv2;
  logic              w_ip1, w_ip2;

  assign w_ilook1 = f_lookup(issue_rs1_tag, cdb_valid, cdb_tag, cdb_val);
  assign w_ilook2 = f_lookup(issue_rs2_tag, cdb_valid, cdb_tag, cdb_val);
  assign w_ip1    = issue_rs1_pend && !w_ilook1[DATA_W];
  assign w_ip2    = issue_rs2_pend && !w_ilook2[DATA_W];
  assign w_iv1    = (issue_rs1_pend && w_ilook1[DATA_W]) ? w_ilook1[DATA_W-1:0] : issue_rs1_val;
  assign w_iv2    = (issue_rs2_pend && w_ilook2[DATA_W]) ? w_ilook2[DATA_W-1:0] : issue_rs2_val;

  logic               w_free_found;
  logic [c_IDX_W-1:0] w_free_idx;

  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!r_busy[i]) begin
        w_free_found = 1'b1;
        w_free_idx   = c_IDX_W'(i);
      end
    end
  end

  logic [DEPTH-1:0]   w_grant;
  logic               w_sel_valid;
  logic [c_IDX_W-1:0] w_sel_idx;

  rs_age_select #(.DEPTH(DEPTH)) u_select (
    .ready (w_ready),
    .older (r_older),
    .grant (w_grant),
    .valid (w_sel_valid)
  );

  always_comb begin
    w_sel_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_grant[i]) w_sel_idx = c_IDX_W'(i);
    end
  end

  logic               w_issue, w_disp;
  logic [c_CNT_W-1:0] w_count_next;

  assign w_issue      = issue_valid && !r_full && w_free_found;
  assign w_disp       = w_sel_valid && (!r_out_valid || out_ready);
  assign w_count_next = r_count + c_CNT_W'(w_issue) - c_CNT_W'(w_disp);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy      <= '0;
      r_p1        <= '0;
      r_p2        <= '0;
      r_older     <= '0;
      r_out_valid <= 1'b0;
      r_out_op    <= '0;
      r_out_f3    <= '0;
      r_out_f7    <= 1'b0;
      r_out_pc    <= '0;
      r_out_imm   <= '0;
      r_out_rob   <= '0;
      r_out_v1    <= '0;
      r_out_v2    <= '0;
      r_count     <= '0;
      r_full      <= 1'b0;
    end else if (flush) begin
      r_busy      <= '0;
      r_out_valid <= 1'b0;
      r_count     <= '0;
      r_full      <= 1'b0;
    end else if (rdy) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_busy[i] && r_p1[i] && w_look1[i][DATA_W]) r_p1[i] <= 1'b0;
        if (r_busy[i] && r_p2[i] && w_look2[i][DATA_W]) r_p2[i] <= 1'b0;
      end
      if (w_disp) begin
        r_busy[w_sel_idx] <= 1'b0;
        r_out_valid       <= 1'b1;
        r_out_op          <= r_op[w_sel_idx];
        r_out_f3          <= r_f3[w_sel_idx];
        r_out_f7          <= r_f7[w_sel_idx];
        r_out_pc          <= r_pc[w_sel_idx];
        r_out_imm         <= r_imm[w_sel_idx];
        r_out_rob         <= r_rob[w_sel_idx];
        r_out_v1          <= r_v1[w_sel_idx];
        r_out_v2          <= r_v2[w_sel_idx];
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      // The dispatched slot is still busy here, so it can never be the free slot.
      if (w_issue) begin
        r_busy[w_free_idx] <= 1'b1;
        r_p1[w_free_idx]   <= w_ip1;
        r_p2[w_free_idx]   <= w_ip2;
        for (int j = 0; j < DEPTH; j++) begin
          r_older[j][w_free_idx] <= r_busy[j];
          r_older[w_free_idx][j] <= 1'b0;
        end
      end
      r_count <= w_count_next;
      r_full  <= (w_count_next == c_CNT_W'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (rdy && !flush && !rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_busy[i] && r_p1[i] && w_look1[i][DATA_W]) r_v1[i] <= w_look1[i][DATA_W-1:0];
        if (r_busy[i] && r_p2[i] && w_look2[i][DATA_W]) r_v2[i] <= w_look2[i][DATA_W-1:0];
      end
      if (w_issue) begin
        r_op[w_free_idx]  <= issue_op;
        r_f3[w_free_idx]  <= issue_funct3;
        r_f7[w_free_idx]  <= issue_funct7;
        r_pc[w_free_idx]  <= issue_pc;
        r_imm[w_free_idx] <= issue_imm;
        r_rob[w_free_idx] <= issue_rob_pos;
        r_t1[w_free_idx]  <= issue_rs1_tag;
        r_t2[w_free_idx]  <= issue_rs2_tag;
        r_v1[w_free_idx]  <= w_iv1;
        r_v2[w_free_idx]  <= w_iv2;
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign out_op      = r_out_op;
  assign out_funct3  = r_out_f3;
  assign out_funct7  = r_out_f7;
  assign out_pc      = r_out_pc;
  assign out_imm     = r_out_imm;
  assign out_rob_pos = r_out_rob;
  assign out_val1    = r_out_v1;
  assign out_val2    = r_out_v2;
  assign full        = r_full;
  assign count       = r_count;

endmodule

`default_nettype wire
